pdm_decoder: RTL and testbench

PDM_DECODER -- requirements
Module: pdm_decoder

---
 rtl/pdm_dec_pkg.sv | 17 +
 rtl/pdm_dec_sync.sv | 27 ++
 rtl/pdm_decoder.sv | 158 +++++++++++++++
 tb/tb_pdm_decoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pdm_dec_pkg.sv
// pdm_dec_pkg: shared types and default sizing for the PDM decimator.
// Holds the decoder FSM state encoding and the default window/output widths.
package pdm_dec_pkg;

    // Default decimation window is 2^5 = 32 PDM bits.
    localparam int DEC_LOG2_DEF = 5;

    // Default PCM result width; full-scale 32 saturates to 31.
    localparam int OUT_W_DEF    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        RUN  = 2'd2
    } dec_state_e;

endpackage

// File: rtl/pdm_dec_sync.sv
// pdm_dec_sync: two-flop synchronizer for the asynchronous PDM input.
// Ports: clk, reset (async, active-high), i_d (raw bit), o_q (synced bit).
module pdm_dec_sync
    import pdm_dec_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pdm_decoder.sv
// pdm_decoder: counts ones over fixed 2^DEC_LOG2-bit windows of a 1-bit PDM
// stream and publishes the saturated count as a PCM sample per window.
// Ports:
//   clk       - clock, all state on rising edge
//   reset     - asynchronous, active-high reset
//   en        - decode enable; low aborts the window and idles the block
//   pdm_in    - 1-bit PDM stream, one bit per clk
//   pcm_out   - last completed window result, held between windows
//   pcm_valid - one-cycle strobe marking a new pcm_out
//   lock      - high while the last two window results are equal
// Build option: define PDM_DEC_SYNC_EN to pass pdm_in through a 2-flop
// synchronizer (pdm_dec_sync) before counting.
module pdm_decoder
    import pdm_dec_pkg::*;
#(
    parameter int DEC_LOG2 = DEC_LOG2_DEF,
    parameter int OUT_W    = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pdm_in,
    output logic [OUT_W-1:0] pcm_out,
    output logic             pcm_valid,
    output logic             lock
);

    // Ones counter must hold 0..N, hence one bit wider than the bit index.
    localparam int SUM_W = DEC_LOG2 + 1;

    // Common width for the saturation compare.
    localparam int CMP_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;

    localparam logic [DEC_LOG2-1:0] LAST_BIT = {DEC_LOG2{1'b1}};
    localparam logic [DEC_LOG2-1:0] CNT_ONE  = DEC_LOG2'(1);
    localparam logic [CMP_W-1:0]    PCM_MAX  = CMP_W'({OUT_W{1'b1}});

    dec_state_e r_state;
    dec_state_e w_state_nxt;

    logic [DEC_LOG2-1:0] r_bit_cnt;
    logic [DEC_LOG2-1:0] w_bit_cnt_nxt;
    logic [SUM_W-1:0]    r_ones;
    logic [SUM_W-1:0]    w_ones_nxt;
    logic [OUT_W-1:0]    r_pcm;
    logic [OUT_W-1:0]    w_pcm_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic                r_lock;
    logic                w_lock_nxt;

    logic                w_bit;
    logic                w_last;
    logic [SUM_W-1:0]    w_sum;
    logic [CMP_W-1:0]    w_sum_x;
    logic [OUT_W-1:0]    w_result;

`ifdef PDM_DEC_SYNC_EN
    // Delays the sampled stream by two cycles; window edges stay on the
    // bit counter, so only data timing shifts.
    pdm_dec_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (pdm_in),
        .o_q   (w_bit)
    );
`else
    assign w_bit = pdm_in;
`endif

    // The completing bit is folded in here so the result uses all N bits.
    assign w_sum   = r_ones + SUM_W'(w_bit);
    assign w_sum_x = CMP_W'(w_sum);
    assign w_last  = (r_bit_cnt == LAST_BIT);

    // A full window of ones (N) does not fit OUT_W bits; clamp to max.
    assign w_result = (w_sum_x > PCM_MAX) ? {OUT_W{1'b1}}
                                          : w_sum_x[OUT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_ones_nxt    = r_ones;
        w_pcm_nxt     = r_pcm;
        w_valid_nxt   = 1'b0;
        w_lock_nxt    = r_lock;

        unique case (r_state)
            IDLE: begin
                // The enabling edge already samples bit 0; counters are
                // zero here since every exit to IDLE clears them.
                if (en) begin
                    w_state_nxt   = ACQ;
                    w_bit_cnt_nxt = r_bit_cnt + CNT_ONE;
                    w_ones_nxt    = w_sum;
                end
            end

            ACQ, RUN: begin
                if (!en) begin
                    // Disable wins over a coincident completion.
                    w_state_nxt   = IDLE;
                    w_bit_cnt_nxt = '0;
                    w_ones_nxt    = '0;
                    w_lock_nxt    = 1'b0;
                end else if (w_last) begin
                    w_state_nxt   = RUN;
                    w_bit_cnt_nxt = '0;
                    w_ones_nxt    = '0;
                    w_pcm_nxt     = w_result;
                    w_valid_nxt   = 1'b1;
                    // The first window has no predecessor to match.
                    w_lock_nxt    = (r_state == RUN) &&
                                    (w_result == r_pcm);
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + CNT_ONE;
                    w_ones_nxt    = w_sum;
                end
            end

            default: begin
                w_state_nxt   = IDLE;
                w_bit_cnt_nxt = '0;
                w_ones_nxt    = '0;
                w_lock_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_ones    <= '0;
            r_pcm     <= '0;
            r_valid   <= 1'b0;
            r_lock    <= 1'b0;
        end else begin
            r_bit_cnt <= w_bit_cnt_nxt;
            r_ones    <= w_ones_nxt;
            r_pcm     <= w_pcm_nxt;
            r_valid   <= w_valid_nxt;
            r_lock    <= w_lock_nxt;
        end
    end

    assign pcm_out   = r_pcm;
    assign pcm_valid = r_valid;
    assign lock      = r_lock;

endmodule

// File: tb/tb_pdm_decoder.sv
// tb_pdm_decoder: scoreboard bench for pdm_decoder (N=32, 5-bit output).
// Stimulus pushes expected strobes; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_pdm_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       pdm_in;
    logic [4:0] pcm_out;
    logic       pcm_valid;
    logic       lock;

    pdm_decoder #(
        .DEC_LOG2 (5),
        .OUT_W    (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .pdm_in    (pdm_in),
        .pcm_out   (pcm_out),
        .pcm_valid (pcm_valid),
        .lock      (lock)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0] pcm;
        logic       lk;
        int         at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   enc_acc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (pcm_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got pcm=%0d at cycle %0d expected none",
                         pcm_out, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_pcm", int'(pcm_out), int'(mon_e.pcm));
                check("strobe_lock", int'(lock), int'(mon_e.lk));
                check("strobe_cycle", cyc, mon_e.at);
            end
        end
    end

    // First-order PDM encoder: exactly k ones per 32 bits at any phase.
    function automatic logic enc_next(input int k);
        enc_acc += k;
        if (enc_acc >= 32) begin
            enc_acc -= 32;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive(input logic e, input logic b);
        en     = e;
        pdm_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_strobe(input int p, input logic l);
        sb.push_back('{pcm: 5'(p), lk: l, at: cyc});
    endtask

    task automatic window(input int k, input int p, input logic l);
        for (int i = 0; i < 32; i++) drive(1'b1, enc_next(k));
        expect_strobe(p, l);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b0;
        en     = 1'b0;
        pdm_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("reset_pcm", int'(pcm_out), 0);
        check("reset_valid", int'(pcm_valid), 0);
        check("reset_lock", int'(lock), 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;

        // Density 19/32 over four windows.
        enc_acc = 0;
        window(19, 19, 1'b0);
        window(19, 19, 1'b1);
        window(19, 19, 1'b1);
        window(19, 19, 1'b1);
        drive(1'b0, 1'b0);
        check("dis_lock_clear", int'(lock), 0);
        check("dis_pcm_hold", int'(pcm_out), 19);
        repeat (5) drive(1'b0, 1'b0);
        check("idle_no_valid", int'(pcm_valid), 0);

        // Constant 1 saturates, constant 0 gives zero.
        enc_acc = 0;
        window(32, 31, 1'b0);
        window(32, 31, 1'b1);
        window(0, 0, 1'b0);
        window(0, 0, 1'b1);
        drive(1'b0, 1'b0);
        check("dis_lock_clear2", int'(lock), 0);

        // Abort at bit 17 of window 2, then re-enable.
        enc_acc = 0;
        window(10, 10, 1'b0);
        for (int i = 0; i < 17; i++) drive(1'b1, enc_next(10));
        drive(1'b0, enc_next(10));
        check("abort_pcm_hold", int'(pcm_out), 10);
        check("abort_lock", int'(lock), 0);
        check("abort_no_valid", int'(pcm_valid), 0);
        repeat (3) drive(1'b0, 1'b0);
        enc_acc = 0;
        window(5, 5, 1'b0);
        drive(1'b0, 1'b0);

        // Reset mid-window clears outputs at once.
        enc_acc = 0;
        window(12, 12, 1'b0);
        window(12, 12, 1'b1);
        for (int i = 0; i < 20; i++) drive(1'b1, enc_next(12));
        #2;
        reset  = 1'b1;
        en     = 1'b0;
        pdm_in = 1'b0;
        #1;
        check("async_rst_pcm", int'(pcm_out), 0);
        check("async_rst_lock", int'(lock), 0);
        check("async_rst_valid", int'(pcm_valid), 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        enc_acc = 0;
        window(7, 7, 1'b0);
        drive(1'b0, 1'b0);

        // Step 8 -> 24 mid-run.
        enc_acc = 0;
        window(8, 8, 1'b0);
        window(8, 8, 1'b1);
        window(24, 24, 1'b0);
        window(24, 24, 1'b1);
        drive(1'b0, 1'b0);

        // Single 1 at bit 31: current window, or next one when synced.
        repeat (3) drive(1'b0, 1'b0);
        for (int i = 0; i < 31; i++) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
`ifdef PDM_DEC_SYNC_EN
        expect_strobe(0, 1'b0);
`else
        expect_strobe(1, 1'b0);
`endif
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b0);
`ifdef PDM_DEC_SYNC_EN
        expect_strobe(1, 1'b0);
`else
        expect_strobe(0, 1'b0);
`endif
        repeat (3) drive(1'b0, 1'b0);

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
